// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single shared memory port.
// One access is outstanding at a time, with a bounded-streak priority scheme.
module mem_arbiter #(
  parameter bit          DATA_PRIO = 1'b1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_byte_en,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_addr,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_en,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        proto_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds its request (and may change its other inputs)
  // until its resp pulse; the request is sampled only in IDLE, and the access
  // completes on the cycle pmem_resp is seen in a BUSY state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] BURST = 4'(MAX_BURST);

  state_t      state, state_n;
  logic [3:0]  streak, streak_n;
  logic        d_req, fav_req, oth_req, take_fav, take_oth;
  logic        grant_i, grant_d;
  logic        op_write;
  logic [15:0] addr_q, wdata_q;
  logic [1:0]  be_q;

  assign d_req   = d_read | d_write;
  assign fav_req = DATA_PRIO ? d_req  : i_read;
  assign oth_req = DATA_PRIO ? i_read : d_req;

  // The favoured port loses only after MAX_BURST straight wins over a waiter.
  assign take_fav = fav_req & ~(oth_req & (streak == BURST));
  assign take_oth = oth_req & ~take_fav;

  always_comb begin
    state_n  = state;
    streak_n = streak;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        grant_d = DATA_PRIO ? take_fav : take_oth;
        grant_i = DATA_PRIO ? take_oth : take_fav;
        if (take_fav) begin
          if (oth_req) streak_n = (streak == BURST) ? BURST : streak + 4'd1;
          else         streak_n = 4'd0;
        end else if (take_oth) begin
          streak_n = 4'd0;
        end
        if (grant_d)      state_n = D_BUSY;
        else if (grant_i) state_n = I_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      streak <= 4'd0;
    end else begin
      state  <= state_n;
      streak <= streak_n;
    end
  end

  // The memory side sees only these registers, so requesters may change their
  // inputs mid-access without disturbing the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      be_q      <= 2'b00;
      op_write  <= 1'b0;
      proto_err <= 1'b0;
    end else if (grant_i) begin
      addr_q   <= i_addr;
      be_q     <= 2'b11;
      op_write <= 1'b0;
    end else if (grant_d) begin
      addr_q   <= d_addr;
      wdata_q  <= d_wdata;
      be_q     <= d_byte_en;
      op_write <= d_write;
      if (d_read && d_write) proto_err <= 1'b1;
    end
  end

  assign pmem_read    = (state != IDLE) & ~op_write;
  assign pmem_write   = (state != IDLE) &  op_write;
  assign pmem_addr    = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_byte_en = be_q;

  assign i_resp    = pmem_resp & (state == I_BUSY);
  assign d_resp    = pmem_resp & (state == D_BUSY);
  assign i_rdata   = pmem_rdata;
  assign d_rdata   = pmem_rdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grant
// order and memory contents; a monitor checks the DUT against queued results.
module tb_mem_arbiter;

  localparam bit DATA_PRIO = 1'b1;
  localparam int MAX_BURST = 4;
  localparam int TXN_W     = 36;

  typedef struct packed {
    logic        port;   // 1 = data port
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } txn_t;

  logic        clk, rst_n;
  logic        i_read, i_resp, d_read, d_write, d_resp;
  logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [1:0]  d_byte_en, pmem_byte_en, dbg_state;
  logic        pmem_read, pmem_write, pmem_resp, proto_err;
  logic [15:0] pmem_addr, pmem_wdata, pmem_rdata;

  mem_arbiter #(.DATA_PRIO(DATA_PRIO), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_byte_en(pmem_byte_en),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [TXN_W-1:0] exp_q[$];
  logic [16:0]      rsp_q[$];
  logic [15:0]      mem [logic [15:0]];
  int checks = 0;
  int errors = 0;

  // reference model / stimulus knobs
  bit   model_busy = 0;
  txn_t cur;
  int   cnt = 0;
  int   m_streak = 0;
  bit   m_proto = 0;
  bit   done_i = 0, done_d = 0;
  int   p_req = 0;
  int   fixed_lat = -1;
  bit   allow_both = 0;
  bit   drop_en = 0;
  bit   mon_en = 0;
  bit   prev_on = 0;
  txn_t mcur;

  task automatic check_val(input string name, input logic [39:0] act, input logic [39:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  function automatic logic [15:0] rand_addr();
    return 16'h2000 + 16'($urandom_range(0, 7));
  endfunction

  // Model step at the rising edge: retire a finished access or pick a winner.
  task automatic model_step();
    txn_t t;
    bit   i_req, d_req, fav, oth, d_win;
    logic [15:0] w;
    if (model_busy) begin
      if (pmem_resp) begin
        model_busy = 0;
        if (cur.wr) begin
          w = mem_rd(cur.addr);
          if (cur.be[0]) w[7:0]  = cur.wdata[7:0];
          if (cur.be[1]) w[15:8] = cur.wdata[15:8];
          mem[cur.addr] = w;
        end
        if (cur.port) done_d = 1; else done_i = 1;
      end
    end else begin
      i_req = i_read;
      d_req = d_read | d_write;
      fav   = DATA_PRIO ? d_req : i_req;
      oth   = DATA_PRIO ? i_req : d_req;
      if (fav || oth) begin
        if (fav && !(oth && m_streak == MAX_BURST)) begin
          d_win    = DATA_PRIO;
          m_streak = oth ? ((m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST) : 0;
        end else begin
          d_win    = !DATA_PRIO;
          m_streak = 0;
        end
        t.port = d_win;
        if (d_win) begin
          t.wr = d_write; t.addr = d_addr; t.wdata = d_wdata; t.be = d_byte_en;
          if (d_read && d_write) m_proto = 1;
        end else begin
          t.wr = 1'b0; t.addr = i_addr; t.wdata = 16'h0; t.be = 2'b11;
        end
        exp_q.push_back(t);
        cur        = t;
        model_busy = 1;
        cnt        = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic raise_d();
    int k;
    k = int'($urandom_range(0, 39));
    d_read  = 1'b0;
    d_write = 1'b0;
    if (allow_both && k == 0) begin d_read = 1'b1; d_write = 1'b1; end
    else if (k < 20)           d_read  = 1'b1;
    else                       d_write = 1'b1;
    d_addr    = rand_addr();
    d_wdata   = 16'($urandom);
    d_byte_en = 2'($urandom_range(0, 3));
  endtask

  // Driver step at the falling edge: requesters and the memory responder.
  task automatic drive_step();
    logic [15:0] rd;
    if (done_i) begin done_i = 0; i_read = 1'b0; end
    if (done_d) begin done_d = 0; d_read = 1'b0; d_write = 1'b0; end
    if (model_busy && !cur.port) begin
      if ($urandom_range(0, 1) == 0) i_addr = 16'($urandom);
      if (drop_en && $urandom_range(0, 3) == 0) i_read = 1'b0;
    end else if (!i_read && int'($urandom_range(0, 99)) < p_req) begin
      i_read = 1'b1;
      i_addr = rand_addr();
    end
    if (model_busy && cur.port) begin
      if ($urandom_range(0, 1) == 0) begin
        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_byte_en = 2'($urandom);
      end
      if (drop_en && $urandom_range(0, 3) == 0) begin d_read = 1'b0; d_write = 1'b0; end
    end else if (!(d_read || d_write) && int'($urandom_range(0, 99)) < p_req) begin
      raise_d();
    end
    if (model_busy) begin
      if (cnt == 0) begin
        rd = cur.wr ? 16'($urandom) : mem_rd(cur.addr);
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        rsp_q.push_back({cur.port, rd});
      end else begin
        cnt--;
        pmem_resp  = 1'b0;
        pmem_rdata = 16'($urandom);
      end
    end else begin
      pmem_resp  = ($urandom_range(0, 7) == 0);
      pmem_rdata = 16'($urandom);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      drive_step();
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic        on;
    logic [16:0] r;
    #2;
    if (mon_en) begin
      on = pmem_read | pmem_write;
      check_val("busy_state", 40'(dbg_state != 2'd0), 40'(model_busy));
      check_val("strobe", 40'(on), 40'(model_busy));
      if (on && !prev_on) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant actual=unexpected_access required=none t=%0t", $time);
        end else begin
          mcur = exp_q.pop_front();
        end
      end
      if (on)
        check_val("pmem_access",
          40'({pmem_write, pmem_read, pmem_addr, pmem_byte_en, mcur.wr ? pmem_wdata : 16'h0}),
          40'({mcur.wr, !mcur.wr, mcur.addr, mcur.be, mcur.wr ? mcur.wdata : 16'h0}));
      prev_on = on;
      if (i_resp || d_resp || rsp_q.size() != 0) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp actual=i%0b_d%0b required=none t=%0t", i_resp, d_resp, $time);
        end else begin
          r = rsp_q.pop_front();
          check_val("resp", 40'({i_resp, d_resp, r[16] ? d_rdata : i_rdata}),
                    40'({!r[16], r[16], r[15:0]}));
        end
      end
      check_val("rdata_pass", 40'({i_rdata, d_rdata}), 40'({pmem_rdata, pmem_rdata}));
      check_val("proto_err", 40'(proto_err), 40'(m_proto));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b1;
    i_read = 1'b0; i_addr = 16'h0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 16'h0; d_wdata = 16'h0; d_byte_en = 2'b00;
    pmem_resp = 1'b0; pmem_rdata = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    check_val("reset_strobes", 40'({pmem_read, pmem_write}), 40'h0);
    check_val("reset_regs", 40'({pmem_addr, pmem_wdata, pmem_byte_en}), 40'h0);
    check_val("reset_proto", 40'(proto_err), 40'h0);
    check_val("reset_state", 40'(dbg_state), 40'h0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;

    // single fetch with response on the third busy cycle
    mem[16'h3000] = 16'h1234;
    fixed_lat = 2;
    i_read = 1'b1; i_addr = 16'h3000;
    run_cycles(6);

    // collision: data port wins first, instruction follows
    fixed_lat = 1;
    i_read = 1'b1; i_addr = 16'h1111;
    d_write = 1'b1; d_read = 1'b0; d_addr = 16'h4000; d_wdata = 16'hBEEF; d_byte_en = 2'b01;
    run_cycles(10);

    // both ports held high continuously: streak limit forces the I grant
    fixed_lat = 0;
    p_req = 100;
    run_cycles(60);

    // free-running random traffic, later with read+write collisions
    fixed_lat = -1;
    p_req = 40;
    drop_en = 1;
    run_cycles(800);
    allow_both = 1;
    run_cycles(700);

    p_req = 0;
    n = 0;
    while ((model_busy || i_read || d_read || d_write) && n < 300) begin
      run_cycles(1);
      n++;
    end
    check_val("drain", 40'(model_busy || i_read || d_read || d_write), 40'h0);
    run_cycles(2);
    #3;
    check_val("queues_empty", 40'(exp_q.size() + rsp_q.size()), 40'h0);

    // read+write together, then reset in the middle of the access
    mon_en = 0;
    prev_on = 0;
    @(negedge clk);
    pmem_resp = 1'b0;
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h5555; d_wdata = 16'hA0A0; d_byte_en = 2'b11;
    @(posedge clk); #1;
    check_val("rw_as_write", 40'({pmem_write, pmem_read, pmem_addr}), 40'({1'b1, 1'b0, 16'h5555}));
    check_val("rw_proto_err", 40'(proto_err), 40'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midreset_strobes", 40'({pmem_read, pmem_write}), 40'h0);
    check_val("midreset_proto", 40'(proto_err), 40'h0);
    check_val("midreset_regs", 40'({pmem_addr, pmem_byte_en, dbg_state}), 40'h0);
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("late_resp", 40'({d_resp, i_resp, pmem_read, pmem_write}), 40'h0);
    end
    pmem_resp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
